// File: rtl/brew_timer_if.sv
// Handshake and display bundle between the brew controller and the brew countdown timer.
interface brew_timer_if;
  logic       start;
  logic       pause;
  logic       cancel;
  logic [3:0] duration;
  logic [3:0] remaining;
  logic       busy;
  logic       tick;
  logic       done;

  modport master (
    output start, pause, cancel, duration,
    input  remaining, busy, tick, done
  );

  modport slave (
    input  start, pause, cancel, duration,
    output remaining, busy, tick, done
  );
endinterface

// File: rtl/brew_timer.sv
// Brew countdown timer: loads a duration in seconds and counts it down once per
// TICK_DIV clocks, with pause and cancel, pulsing done on a natural finish.
module brew_timer #(
  parameter int TICK_DIV     = 50000000,
  parameter int MAX_DURATION = 15
) (
  input logic        clk,
  input logic        rst_n,
  brew_timer_if.slave bus
);

  localparam int              PW    = $clog2(TICK_DIV);
  localparam logic [PW-1:0]   LAST  = PW'(TICK_DIV - 1);
  localparam logic [PW-1:0]   ONE   = PW'(1);
  localparam logic [3:0]      MAX_D = 4'(MAX_DURATION);

  typedef enum logic [1:0] {IDLE, RUN, PAUSED} state_t;

  state_t        state, state_n;
  logic [PW-1:0] prescaler, prescaler_n;
  logic [3:0]    remaining, remaining_n;
  logic          busy, busy_n;
  logic          tick, tick_n;
  logic          done, done_n;
  logic [3:0]    load;

  assign load = (bus.duration > MAX_D) ? MAX_D : bus.duration;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      prescaler <= '0;
      remaining <= '0;
      busy      <= 1'b0;
      tick      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_n;
      prescaler <= prescaler_n;
      remaining <= remaining_n;
      busy      <= busy_n;
      tick      <= tick_n;
      done      <= done_n;
    end
  end

  // Leaving PAUSED counts on the same edge, so a pause costs exactly its high cycles.
  always_comb begin
    state_n     = state;
    prescaler_n = prescaler;
    remaining_n = remaining;
    busy_n      = busy;
    tick_n      = 1'b0;
    done_n      = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          if (bus.duration != 4'd0) begin
            remaining_n = load;
            prescaler_n = '0;
            busy_n      = 1'b1;
            state_n     = RUN;
          end else begin
            done_n = 1'b1;
          end
        end
      end
      RUN, PAUSED: begin
        if (bus.cancel) begin
          remaining_n = '0;
          busy_n      = 1'b0;
          state_n     = IDLE;
        end else if (bus.pause) begin
          state_n = PAUSED;
        end else begin
          state_n = RUN;
          if (prescaler == LAST) begin
            prescaler_n = '0;
            if (remaining != 4'd0) begin
              remaining_n = remaining - 4'd1;
              tick_n      = 1'b1;
              if (remaining == 4'd1) begin
                done_n  = 1'b1;
                busy_n  = 1'b0;
                state_n = IDLE;
              end
            end
          end else begin
            prescaler_n = prescaler + ONE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign bus.remaining = remaining;
  assign bus.busy      = busy;
  assign bus.tick      = tick;
  assign bus.done      = done;

endmodule

// File: tb/tb_brew_timer.sv
// Randomized bench for brew_timer: two instances (clamp at 15 and at 9) share stimulus
// and are compared every cycle against a seconds/cycles-to-next-step reference model.
module tb_brew_timer;

  localparam int TD = 4;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  brew_timer_if bus15 ();
  brew_timer_if bus9 ();

  brew_timer #(.TICK_DIV(TD), .MAX_DURATION(15)) dut15 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus15.slave)
  );

  brew_timer #(.TICK_DIV(TD), .MAX_DURATION(9)) dut9 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus9.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: seconds left plus cycles until the next step; pause freezes time.
  typedef struct {
    bit active;
    int left;
    int until_step;
    bit tick;
    bit done;
  } model_t;

  model_t m15;
  model_t m9;

  function automatic model_t modelReset();
    model_t m;
    m.active     = 1'b0;
    m.left       = 0;
    m.until_step = 0;
    m.tick       = 1'b0;
    m.done       = 1'b0;
    return m;
  endfunction

  function automatic model_t modelStep(model_t m, bit s, bit p, bit c, int d, int maxd);
    model_t n = m;
    n.tick = 1'b0;
    n.done = 1'b0;
    if (!m.active) begin
      if (s) begin
        if (d == 0) begin
          n.done = 1'b1;
        end else begin
          n.active     = 1'b1;
          n.left       = (d > maxd) ? maxd : d;
          n.until_step = TD;
        end
      end
    end else if (c) begin
      n.active = 1'b0;
      n.left   = 0;
    end else if (!p) begin
      n.until_step = m.until_step - 1;
      if (n.until_step == 0) begin
        n.until_step = TD;
        n.left       = m.left - 1;
        n.tick       = 1'b1;
        if (n.left == 0) begin
          n.active = 1'b0;
          n.done   = 1'b1;
        end
      end
    end
    return n;
  endfunction

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checks++;
    if (observed != expected) begin
      errors++;
      $display("[TB] FAIL %s at %0t: got %0d, expected %0d", tag, $time, observed, expected);
    end
  endtask

  task automatic compareAll();
    checkOutput("remaining15", int'(bus15.remaining), m15.left);
    checkOutput("busy15",      int'(bus15.busy),      int'(m15.active));
    checkOutput("tick15",      int'(bus15.tick),      int'(m15.tick));
    checkOutput("done15",      int'(bus15.done),      int'(m15.done));
    checkOutput("remaining9",  int'(bus9.remaining),  m9.left);
    checkOutput("busy9",       int'(bus9.busy),       int'(m9.active));
    checkOutput("tick9",       int'(bus9.tick),       int'(m9.tick));
    checkOutput("done9",       int'(bus9.done),       int'(m9.done));
  endtask

  // Drive one cycle of inputs on the falling edge, advance the models, check after the rise.
  task automatic applyStimulus(input bit s, input bit p, input bit c, input logic [3:0] d);
    @(negedge clk);
    bus15.start = s; bus15.pause = p; bus15.cancel = c; bus15.duration = d;
    bus9.start  = s; bus9.pause  = p; bus9.cancel  = c; bus9.duration  = d;
    @(posedge clk);
    m15 = modelStep(m15, s, p, c, int'(d), 15);
    m9  = modelStep(m9,  s, p, c, int'(d), 9);
    #1;
    compareAll();
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, 4'd0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    m15 = modelReset();
    m9  = modelReset();
    rst_n = 1'b0;
    bus15.start = 1'b0; bus15.pause = 1'b0; bus15.cancel = 1'b0; bus15.duration = 4'd0;
    bus9.start  = 1'b0; bus9.pause  = 1'b0; bus9.cancel  = 1'b0; bus9.duration  = 4'd0;
    repeat (2) @(posedge clk);
    #1;
    compareAll();
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] directed: plain run of 3");
    applyStimulus(1'b1, 1'b0, 1'b0, 4'd3);
    idleCycles(14);

    $display("[TB] directed: run of 3 with a 5-cycle pause after the first step");
    applyStimulus(1'b1, 1'b0, 1'b0, 4'd3);
    idleCycles(4);
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b1, 1'b0, 4'd0);
    idleCycles(12);

    $display("[TB] directed: cancel at remaining 6");
    applyStimulus(1'b1, 1'b0, 1'b0, 4'd9);
    idleCycles(12);
    applyStimulus(1'b0, 1'b0, 1'b1, 4'd0);
    idleCycles(3);

    $display("[TB] directed: zero duration, start while busy, clamp, start with cancel");
    applyStimulus(1'b1, 1'b0, 1'b0, 4'd0);
    idleCycles(2);
    applyStimulus(1'b1, 1'b0, 1'b0, 4'd5);
    idleCycles(3);
    applyStimulus(1'b1, 1'b0, 1'b0, 4'd2);
    idleCycles(20);
    applyStimulus(1'b1, 1'b0, 1'b1, 4'd12);
    idleCycles(6);

    $display("[TB] directed: asynchronous reset mid-run");
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    m15 = modelReset();
    m9  = modelReset();
    compareAll();
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(1'b1, 1'b0, 1'b0, 4'd2);
    idleCycles(10);

    $display("[TB] randomized traffic");
    for (int i = 0; i < 4000; i++) begin
      bit s, p, c;
      logic [3:0] d;
      s = ($urandom_range(0, 7) == 0);
      p = ($urandom_range(0, 9) == 0);
      c = ($urandom_range(0, 59) == 0);
      d = 4'($urandom_range(0, 15));
      applyStimulus(s, p, c, d);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
